// File: rtl/prefix_carry_pipe.sv
// Pipelined Kogge-Stone carry network: one prefix level per stage, valid/ready at both ends.
// Stage s (0-based) combines each bit with the bit 2^s places below it.
module prefix_carry_pipe #(
    parameter int WIDTH  = 16,
    parameter int LEVELS = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_g,
    input  logic [WIDTH-1:0] in_p,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_carry,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    logic [WIDTH-1:0]  g_q     [LEVELS];
    logic [WIDTH-1:0]  p_q     [LEVELS];
    logic [WIDTH-1:0]  pin_q   [LEVELS];
    logic [LEVELS-1:0] vld_q;
    logic [LEVELS-1:0] cin_q;

    logic [WIDTH-1:0]  g_src   [LEVELS];
    logic [WIDTH-1:0]  p_src   [LEVELS];
    logic [WIDTH-1:0]  pin_src [LEVELS];
    logic [WIDTH-1:0]  g_nxt   [LEVELS];
    logic [WIDTH-1:0]  p_nxt   [LEVELS];
    logic [LEVELS-1:0] vld_src;
    logic [LEVELS-1:0] cin_src;
    logic [LEVELS-1:0] load;
    logic              chain;

    always_comb begin
        // carry-in is folded into bit 0 so G becomes the true carry after the last level
        g_src[0]   = {in_g[WIDTH-1:1], in_g[0] | (in_p[0] & in_cin)};
        p_src[0]   = in_p;
        pin_src[0] = in_p;
        vld_src[0] = in_valid;
        cin_src[0] = in_cin;
        for (int s = 1; s < LEVELS; s++) begin
            g_src[s]   = g_q[s-1];
            p_src[s]   = p_q[s-1];
            pin_src[s] = pin_q[s-1];
            vld_src[s] = vld_q[s-1];
            cin_src[s] = cin_q[s-1];
        end
        // shifted-in zeros make bits below the distance pass through unchanged
        for (int s = 0; s < LEVELS; s++) begin
            g_nxt[s] = g_src[s] | (p_src[s] & (g_src[s] << (1 << s)));
            p_nxt[s] = p_src[s] & ((p_src[s] << (1 << s)) | ~({WIDTH{1'b1}} << (1 << s)));
        end
    end

    always_comb begin
        load  = '0;
        chain = out_ready;
        for (int s = LEVELS - 1; s >= 0; s--) begin
            chain   = ~vld_q[s] | chain;
            load[s] = chain;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cin_q <= '0;
            for (int s = 0; s < LEVELS; s++) begin
                g_q[s]   <= '0;
                p_q[s]   <= '0;
                pin_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < LEVELS; s++) begin
                if (load[s]) begin
                    vld_q[s] <= vld_src[s];
                    cin_q[s] <= cin_src[s];
                    g_q[s]   <= g_nxt[s];
                    p_q[s]   <= p_nxt[s];
                    pin_q[s] <= pin_src[s];
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = vld_q[LEVELS-1];
    assign out_carry = g_q[LEVELS-1];
    assign out_sum   = pin_q[LEVELS-1] ^ {g_q[LEVELS-1][WIDTH-2:0], cin_q[LEVELS-1]};
    assign out_cout  = g_q[LEVELS-1][WIDTH-1];
    assign out_ovf   = g_q[LEVELS-1][WIDTH-1] ^ g_q[LEVELS-1][WIDTH-2];

endmodule

// File: tb/tb_prefix_carry_pipe.sv
// Directed and streaming checks for prefix_carry_pipe at WIDTH=16.
module tb_prefix_carry_pipe;

    localparam int WIDTH  = 16;
    localparam int LEVELS = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_g;
    logic [WIDTH-1:0] in_p;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_carry;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    int vectors     = 0;
    int miscompares = 0;

    prefix_carry_pipe #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_g(in_g), .in_p(in_p), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_carry(out_carry), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    // ripple-carry reference: {carry, sum, cout, ovf}
    function automatic logic [33:0] model(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [15:0] cy;
        logic        r;
        logic [16:0] total;
        r = c;
        for (int i = 0; i < 16; i++) begin
            r     = (a[i] & b[i]) | ((a[i] ^ b[i]) & r);
            cy[i] = r;
        end
        total = {1'b0, a} + {1'b0, b} + {16'd0, c};
        return {cy, total[15:0], total[16], cy[15] ^ cy[14]};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_g = '0; in_p = '0; in_cin = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
        vectors++;
        if ({out_carry, out_sum, out_cout, out_ovf} !== 34'd0) begin
            miscompares++;
            $display("FAIL reset_data: carry=%h sum=%h cout=%b ovf=%b, required all zero",
                     out_carry, out_sum, out_cout, out_ovf);
        end
    endtask

    task automatic apply_one(input string name, input logic [15:0] g, input logic [15:0] p, input logic c,
                             input logic [15:0] e_carry, input logic [15:0] e_sum,
                             input logic e_cout, input logic e_ovf);
        int cnt;
        @(posedge clk);
        #1 in_valid = 1'b1; in_g = g; in_p = p; in_cin = c; out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_in_ready: got %b, required 1", name, in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0; in_g = '0; in_p = '0; in_cin = 1'b0;
        cnt = 1;
        @(negedge clk);
        while (out_valid !== 1'b1 && cnt < 12) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        vectors++;
        if (cnt != LEVELS) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, cnt, LEVELS);
        end
        vectors++;
        if ({out_carry, out_sum, out_cout, out_ovf} !== {e_carry, e_sum, e_cout, e_ovf}) begin
            miscompares++;
            $display("FAIL %s_result: carry=%h sum=%h cout=%b ovf=%b, required carry=%h sum=%h cout=%b ovf=%b",
                     name, out_carry, out_sum, out_cout, out_ovf, e_carry, e_sum, e_cout, e_ovf);
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_single_beat: out_valid=%b one cycle later, required 0", name, out_valid);
        end
    endtask

    task automatic test_directed();
        apply_one("ffff_plus_1", 16'h0001, 16'hFFFE, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        apply_one("prop_cin1",   16'h0000, 16'hFFFF, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        apply_one("prop_cin0",   16'h0000, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
        apply_one("7fff_plus_1", 16'h0001, 16'h7FFE, 1'b0, 16'h7FFF, 16'h8000, 1'b0, 1'b1);
        apply_one("8000_plus_8000", 16'h8000, 16'h0000, 1'b0, 16'h8000, 16'h0000, 1'b1, 1'b1);
    endtask

    task automatic run_stream(input string name, input int nbeats, input int vld_pct, input int rdy_pct,
                              input int max_cycles, output int first_out, output int last_out);
        logic [33:0] q[$];
        logic [33:0] obs, held, exp_v;
        logic [15:0] a, b;
        logic        c;
        logic        stall;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0; stall = 1'b0; held = '0;
        first_out = -1; last_out = -1;
        @(posedge clk);
        #1;
        a = 16'($urandom); b = 16'($urandom); c = 1'($urandom_range(0, 1));
        in_g = a & b; in_p = a ^ b; in_cin = c;
        in_valid  = ($urandom_range(0, 99) < vld_pct);
        out_ready = ($urandom_range(0, 99) < rdy_pct);
        while ((sent < nbeats || got < sent) && cyc < max_cycles) begin
            @(negedge clk);
            obs = {out_carry, out_sum, out_cout, out_ovf};
            if (stall) begin
                vectors++;
                if (out_valid !== 1'b1 || obs !== held) begin
                    miscompares++;
                    $display("FAIL %s_stall_hold: valid=%b data=%h, required 1/%h", name, out_valid, obs, held);
                end
            end
            vectors++;
            if (in_ready !== ((q.size() < LEVELS) || out_ready)) begin
                miscompares++;
                $display("FAIL %s_in_ready: got %b with %0d in flight out_ready=%b", name, in_ready, q.size(), out_ready);
            end
            if (out_valid === 1'b1 && out_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s_spurious: output %h with nothing in flight", name, obs);
                end else begin
                    exp_v = q.pop_front();
                    if (obs !== exp_v) begin
                        miscompares++;
                        $display("FAIL %s_data: got %h, required %h (beat %0d)", name, obs, exp_v, got);
                    end
                end
                got++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            if (in_valid && in_ready === 1'b1) begin
                q.push_back(model(a, b, c));
                sent++;
            end
            stall = (out_valid === 1'b1) && !out_ready;
            held  = obs;
            @(posedge clk);
            #1;
            cyc++;
            a = 16'($urandom); b = 16'($urandom); c = 1'($urandom_range(0, 1));
            in_g = a & b; in_p = a ^ b; in_cin = c;
            in_valid  = (sent < nbeats) && ($urandom_range(0, 99) < vld_pct);
            out_ready = ($urandom_range(0, 99) < rdy_pct);
        end
        vectors++;
        if (got != nbeats || q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_complete: %0d results of %0d after %0d cycles", name, got, nbeats, cyc);
        end
        in_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        int f, l;
        run_stream("b2b", 100, 100, 100, 400, f, l);
        vectors++;
        if (l - f != 99) begin
            miscompares++;
            $display("FAIL b2b_rate: 100 results spanned %0d cycles, required 100", l - f + 1);
        end
    endtask

    task automatic test_backpressure();
        int f, l;
        run_stream("bp", 80, 70, 50, 2000, f, l);
    endtask

    task automatic test_reset_midstream();
        @(posedge clk);
        #1 out_ready = 1'b0; in_valid = 1'b1; in_g = 16'h00FF; in_p = 16'hFF00; in_cin = 1'b1;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_prefill: out_valid=%b before reset, required 1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_async: out_valid=%b during reset, required 0", out_valid);
        end
        @(posedge clk);
        #1 rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_in_ready: got %b after release, required 1", in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL midrst_stale: out_valid=%b cycle %0d after release, required 0", out_valid, i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
